train_scheduler: RTL

- Sequences DNN training in hardware.
- Owns the block-cycle counter and the feed select to the input and ideal-output muxes, and steps the training-case index and epoch.
- Scores each case by comparing the DNN thresholded outputs against the ideal outputs, and keeps total and sliding-window accuracy.
- Sits between the training-data memories/muxes and the DNN top; replaces the free-running cycle counter and testbench-side scoring.

---
 rtl/dnn_ctrl_pkg.sv | 15 +
 rtl/accuracy_window.sv | 39 +++
 rtl/train_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dnn_ctrl_pkg.sv
// Shared types and width helper for the DNN training sequencer.
package dnn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } sched_state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accuracy_window.sv
// Sliding-window correct count over the last checklast case results.
module accuracy_window
  import dnn_ctrl_pkg::*;
#(
  parameter int unsigned checklast = 1000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push,
  input  logic                                 push_bit,
  output logic [width_of(checklast+1)-1:0]     recent
);

  localparam int unsigned PW = width_of(checklast);
  localparam int unsigned RW = width_of(checklast + 1);

  logic [checklast-1:0] r_ring;
  logic [PW-1:0]        r_wptr;
  logic [RW-1:0]        r_recent;
  logic                 w_evict;

  // The evicted bit is the old slot value, read before this clock's write.
  assign w_evict = r_ring[r_wptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ring   <= '0;
      r_wptr   <= '0;
      r_recent <= '0;
    end else if (push) begin
      r_recent       <= r_recent - RW'(w_evict) + RW'(push_bit);
      r_ring[r_wptr] <= push_bit;
      r_wptr         <= (r_wptr == PW'(checklast - 1)) ? '0 : r_wptr + PW'(1);
    end
  end

  assign recent = r_recent;

endmodule

// File: rtl/train_scheduler.sv
// Block-cycle sequencer for DNN training: feed select, case/epoch stepping,
// per-case scoring and accuracy accounting.
module train_scheduler
  import dnn_ctrl_pkg::*;
#(
  parameter int unsigned cpc            = 18,
  parameter int unsigned pipe_delay     = 2,
  parameter int unsigned n_out          = 16,
  parameter int unsigned training_cases = 10000,
  parameter int unsigned num_epochs     = 10,
  parameter int unsigned checklast      = 1000
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        pause,
  input  logic [n_out-1:0]                            a_out_alln,
  input  logic                                        y_out,
  output logic [width_of(cpc)-1:0]                    cycle_index,
  output logic                                        cycle_clk,
  output logic [width_of(cpc-pipe_delay)-1:0]         sel_network,
  output logic                                        feed_valid,
  output logic [width_of(training_cases)-1:0]         sel_tc,
  output logic [width_of(num_epochs+1)-1:0]           epoch,
  output logic [31:0]                                 num_train,
  output logic                                        correct,
  output logic                                        result_valid,
  output logic [width_of(checklast+1)-1:0]            recent,
  output logic [31:0]                                 total_correct,
  output logic                                        done
);

  localparam int unsigned CIW   = width_of(cpc);
  localparam int unsigned SNW   = width_of(cpc - pipe_delay);
  localparam int unsigned TCW   = width_of(training_cases);
  localparam int unsigned EPW   = width_of(num_epochs + 1);
  localparam int unsigned CAPW  = width_of(n_out);
  localparam logic [31:0] TOTAL = 32'(training_cases * num_epochs);

  sched_state_e     r_state, w_next_state;
  logic [CIW-1:0]   r_ci;
  logic [n_out-2:0] r_cap;
  logic [TCW-1:0]   r_sel_tc;
  logic [EPW-1:0]   r_epoch;
  logic [31:0]      r_num_train;
  logic [31:0]      r_total;
  logic             r_correct;
  logic             r_result_valid;
  logic             r_done;

  logic             w_block_end;
  logic             w_final;
  logic             w_corr;
  logic             w_feed_valid;
  logic [CAPW-1:0]  w_cap_idx;

  assign w_block_end  = (r_state == RUN) && (r_ci == CIW'(cpc - 1));
  assign w_final      = w_block_end && ((r_num_train + 32'd1) == TOTAL);
  assign w_feed_valid = (r_state == RUN) && (32'(r_ci) < (cpc - pipe_delay));
  assign w_cap_idx    = CAPW'(32'(r_ci) - pipe_delay);
  // The top result bit arrives on the scoring clock itself, so it bypasses the capture register.
  assign w_corr       = (a_out_alln == {y_out, r_cap});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = RUN;
      RUN: begin
        if (w_block_end) begin
          if (w_final)    w_next_state = DONE;
          else if (pause) w_next_state = HOLD;
        end
      end
      HOLD: if (!pause) w_next_state = RUN;
      DONE: w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ci <= '0;
    end else if ((r_state == RUN) && !w_block_end) begin
      r_ci <= r_ci + CIW'(1);
    end else begin
      r_ci <= '0;
    end
  end

  // The final output bit is never stored; it is scored straight from y_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap <= '0;
    end else if ((r_state == RUN) && (32'(r_ci) >= pipe_delay) &&
                 (32'(w_cap_idx) < (n_out - 1))) begin
      r_cap[w_cap_idx] <= y_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_correct      <= 1'b0;
      r_result_valid <= 1'b0;
      r_num_train    <= '0;
      r_total        <= '0;
      r_sel_tc       <= '0;
      r_epoch        <= EPW'(1);
      r_done         <= 1'b0;
    end else begin
      r_result_valid <= w_block_end;
      if (w_block_end) begin
        r_correct   <= w_corr;
        r_num_train <= r_num_train + 32'd1;
        r_total     <= r_total + 32'(w_corr);
        if (r_sel_tc == TCW'(training_cases - 1)) begin
          r_sel_tc <= '0;
          if (!w_final) r_epoch <= r_epoch + EPW'(1);
        end else begin
          r_sel_tc <= r_sel_tc + TCW'(1);
        end
        if (w_final) r_done <= 1'b1;
      end
    end
  end

  accuracy_window #(
    .checklast(checklast)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .push     (w_block_end),
    .push_bit (w_corr),
    .recent   (recent)
  );

  assign cycle_index   = r_ci;
  assign cycle_clk     = w_block_end;
  assign feed_valid    = w_feed_valid;
  assign sel_network   = w_feed_valid ? SNW'(r_ci) : '0;
  assign sel_tc        = r_sel_tc;
  assign epoch         = r_epoch;
  assign num_train     = r_num_train;
  assign correct       = r_correct;
  assign result_valid  = r_result_valid;
  assign total_correct = r_total;
  assign done          = r_done;

endmodule
